// File: rtl/color_pkg.sv
// color_pkg: colour codes and voter FSM states shared with the overlay and game logic.
package color_pkg;
  typedef enum logic [1:0] {
    COLOR_NONE  = 2'd0,
    COLOR_RED   = 2'd1,
    COLOR_GREEN = 2'd2,
    COLOR_BLUE  = 2'd3
  } color_t;
  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SNAP   = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;
endpackage

// File: rtl/roi_color_voter_if.sv
// roi_color_voter_if: pixel stream in, ROI flag and per-frame colour statistics out.
interface roi_color_voter_if #(
  parameter int CNT_W = 14
);
  import color_pkg::*;
  logic [9:0]       x_coord;
  logic [9:0]       y_coord;
  logic             display_enable;
  logic             is_red;
  logic             is_green;
  logic             is_blue;
  logic             in_roi;
  color_t           dominant_color;
  color_t           candidate_color;
  logic             decision_valid;
  logic [CNT_W-1:0] red_count;
  logic [CNT_W-1:0] green_count;
  logic [CNT_W-1:0] blue_count;
  modport master (
    output x_coord, y_coord, display_enable, is_red, is_green, is_blue,
    input  in_roi, dominant_color, candidate_color, decision_valid, red_count, green_count, blue_count
  );
  modport slave (
    input  x_coord, y_coord, display_enable, is_red, is_green, is_blue,
    output in_roi, dominant_color, candidate_color, decision_valid, red_count, green_count, blue_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear still honours a same-cycle increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? W'(inc) : (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/roi_color_voter.sv
// roi_color_voter: counts classified pixels inside the ROI, votes a colour per frame
// and debounces the vote over consecutive frames.
module roi_color_voter
  import color_pkg::*;
#(
  parameter logic [9:0]  ROI_X_START   = 10'd100,
  parameter logic [9:0]  ROI_X_END     = 10'd220,
  parameter logic [9:0]  ROI_Y_START   = 10'd60,
  parameter logic [9:0]  ROI_Y_END     = 10'd180,
  parameter int          CNT_W         = 14,
  parameter int unsigned MIN_PIXELS    = 1000,
  parameter int          STABLE_FRAMES = 3
) (
  input logic              clk,
  input logic              reset,
  roi_color_voter_if.slave bus
);
  state_t           state_q, state_d;
  logic             past_q, past_d, past_prev_q;
  logic             armed_q, armed_d, dv_q, dv_d, eor, clr;
  logic [3:0]       stable_q, stable_d;
  color_t           cand_q, cand_d, dom_q, dom_d, cand_new;
  logic [CNT_W-1:0] snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
  logic [CNT_W-1:0] live_r, live_g, live_b, mx_rg, mx;
  logic [1:0]       n_max;
  assign bus.in_roi = bus.display_enable &&
                      bus.x_coord >= ROI_X_START && bus.x_coord < ROI_X_END &&
                      bus.y_coord >= ROI_Y_START && bus.y_coord < ROI_Y_END;
  assign past_d = bus.y_coord >= ROI_Y_END;
  assign eor    = past_q && !past_prev_q;
  assign clr    = state_q == ST_SNAP;
  sat_counter #(.W(CNT_W)) u_red (
    .clk(clk), .reset(reset), .clr(clr), .inc(bus.in_roi && bus.is_red), .q(live_r)
  );
  sat_counter #(.W(CNT_W)) u_green (
    .clk(clk), .reset(reset), .clr(clr), .inc(bus.in_roi && !bus.is_red && bus.is_green), .q(live_g)
  );
  sat_counter #(.W(CNT_W)) u_blue (
    .clk(clk), .reset(reset), .clr(clr),
    .inc(bus.in_roi && !bus.is_red && !bus.is_green && bus.is_blue), .q(live_b)
  );
  // A colour wins only if it alone holds the maximum and that maximum clears the threshold.
  always_comb begin
    mx_rg    = snap_r_q > snap_g_q ? snap_r_q : snap_g_q;
    mx       = snap_b_q > mx_rg ? snap_b_q : mx_rg;
    n_max    = 2'(snap_r_q == mx) + 2'(snap_g_q == mx) + 2'(snap_b_q == mx);
    cand_new = (32'(mx) < MIN_PIXELS || n_max > 2'd1) ? COLOR_NONE :
               snap_r_q == mx ? COLOR_RED : snap_g_q == mx ? COLOR_GREEN : COLOR_BLUE;
  end
  always_comb begin
    state_d  = state_q == ST_SNAP ? ST_DECIDE : state_q == ST_DECIDE ? ST_ACCUM : eor ? ST_SNAP : ST_ACCUM;
    armed_d  = armed_q;
    dv_d     = 1'b0;
    cand_d   = cand_q;
    dom_d    = dom_q;
    stable_d = stable_q;
    snap_r_d = (clr && armed_q) ? live_r : snap_r_q;
    snap_g_d = (clr && armed_q) ? live_g : snap_g_q;
    snap_b_d = (clr && armed_q) ? live_b : snap_b_q;
    if (state_q == ST_DECIDE) begin
      armed_d = 1'b1;
      if (armed_q) begin
        dv_d     = 1'b1;
        cand_d   = cand_new;
        stable_d = cand_new != cand_q ? 4'd1 : stable_q == 4'(STABLE_FRAMES) ? stable_q : stable_q + 4'd1;
        dom_d    = stable_d == 4'(STABLE_FRAMES) ? cand_new : dom_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      past_q      <= 1'b0;
      past_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      dv_q        <= 1'b0;
      cand_q      <= COLOR_NONE;
      dom_q       <= COLOR_NONE;
      stable_q    <= '0;
      snap_r_q    <= '0;
      snap_g_q    <= '0;
      snap_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      past_q      <= past_d;
      past_prev_q <= past_q;
      armed_q     <= armed_d;
      dv_q        <= dv_d;
      cand_q      <= cand_d;
      dom_q       <= dom_d;
      stable_q    <= stable_d;
      snap_r_q    <= snap_r_d;
      snap_g_q    <= snap_g_d;
      snap_b_q    <= snap_b_d;
    end
  end
  assign bus.dominant_color  = dom_q;
  assign bus.candidate_color = cand_q;
  assign bus.decision_valid  = dv_q;
  assign bus.red_count       = snap_r_q;
  assign bus.green_count     = snap_g_q;
  assign bus.blue_count      = snap_b_q;
endmodule

// File: doc/roi_color_voter.md
Name: roi_color_voter

Overview:
- Per-frame colour statistics stage directly upstream of the display overlay.
- Generates `in_roi` from the VGA coordinates and counts classified red, green and blue pixels inside the ROI over each frame.
- At end of ROI scan, picks a per-frame candidate colour (threshold plus strict majority), then debounces it over consecutive frames.
- Drives `dominant_color` to the overlay's indicator box and exports the raw counts for debug and game logic.

Parameters:
- ROI_X_START, 10'd100, first ROI column (inclusive)
- ROI_X_END, 10'd220, ROI column bound (exclusive)
- ROI_Y_START, 10'd60, first ROI row (inclusive)
- ROI_Y_END, 10'd180, ROI row bound (exclusive)
- CNT_W, 14, width of each pixel counter; must hold (X_END-X_START)*(Y_END-Y_START)
- MIN_PIXELS, 14'd1000, minimum winning count for a non-NONE candidate
- STABLE_FRAMES, 3, consecutive identical candidates required before `dominant_color` changes (range 1..15)

Ports:
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- x_coord  in  10  current pixel column
- y_coord  in  10  current pixel row
- display_enable  in  1  active-video qualifier
- is_red  in  1  pixel classified red, aligned with coords
- is_green  in  1  pixel classified green, aligned with coords
- is_blue  in  1  pixel classified blue, aligned with coords
- in_roi  out  1  combinational: display_enable and coords inside ROI
- dominant_color  out  2  debounced result; NONE=00, RED=01, GREEN=10, BLUE=11
- candidate_color  out  2  last per-frame candidate
- decision_valid  out  1  one-cycle pulse per frame decision
- red_count  out  CNT_W  snapshot of previous frame's red count
- green_count  out  CNT_W  snapshot of previous frame's green count
- blue_count  out  CNT_W  snapshot of previous frame's blue count

Behaviour:
- Clocking and reset:
  - Single clock domain: `clk`.
  - `reset` is synchronous and active-high.
  - All registers clear on reset: counts 0, colours NONE, `decision_valid` 0, `stable_cnt` 0, `armed` 0.
- Counting, done every cycle when `in_roi` is high:
  - Exactly one counter increments, with priority red > green > blue.
  - No increment when no flag is set.
  - Counters saturate at all-ones; they never wrap.
- End of ROI (EOR) detection:
  - `past_roi = (y_coord >= ROI_Y_END)` is registered.
  - `eor` is the rising edge of the registered `past_roi`, so exactly one pulse per frame. Rows after ROI_Y_END and the wrap to row 0 generate no further pulses.
- FSM states:
  - ACCUM: counting. On `eor`, go to SNAP.
  - SNAP, one cycle: copy live counters to the `*_count` outputs, clear the live counters, go to DECIDE.
  - DECIDE, one cycle: compute the candidate, update the stability logic, pulse `decision_valid`, return to ACCUM.
  - A pixel with `in_roi` high during SNAP or DECIDE cannot occur for a legal ROI. If it does, it is counted into the cleared counters.
- Candidate rule:
  - max = largest of the three snapshot counts.
  - Candidate is NONE if max < MIN_PIXELS, or if two or more counts equal max (tie).
  - Otherwise the candidate is the colour holding max.
- Stability logic:
  - If candidate equals the previous candidate, `stable_cnt` increments, saturating at STABLE_FRAMES.
  - Otherwise `stable_cnt` = 1.
  - `dominant_color` is loaded with the candidate when `stable_cnt` (next value) equals STABLE_FRAMES.
  - A NONE candidate is debounced exactly like a colour.
- Latency: `decision_valid` and updated outputs become visible 3 clk edges after the first sampled cycle with `y_coord >= ROI_Y_END`.
- Reset mid-frame:
  - `armed` is 0 after reset.
  - The first `eor` after reset discards the partial frame: counts clear, no candidate, no `decision_valid`. That `eor` sets `armed`.
- `display_enable` low: no counting, and `in_roi` is low.

Decomposition:
- Package `color_pkg`: `color_t` 2-bit enum (COLOR_NONE, COLOR_RED, COLOR_GREEN, COLOR_BLUE) and the FSM state enum. Shared with the overlay and game logic.
- Optional sub-module `sat_counter` (width-parameterised, with clear and increment), instantiated three times.
- Candidate comparison stays inline.

Test Plan:
- Disarm frame: reset, then one full frame of all-red pixels -> no `decision_valid`, `dominant_color`=00.
- Red acquisition: three further all-red frames -> `red_count`=14400 and `candidate_color`=01 each frame; `dominant_color` becomes 01 at the third decision and not earlier.
- Below threshold: frame with 999 red and the rest unclassified -> candidate 00; 1000 red -> candidate 01.
- Tie: 5000 red, 5000 green, 100 blue -> candidate 00. Pixels with `is_red` and `is_blue` both set count only as red.
- Switching colour: after steady RED, two blue frames then one red frame -> `dominant_color` stays 01 and `stable_cnt` restarts at 1; three blue frames -> 11.
- Saturation and gating, with CNT_W=8: 300 green pixels -> `green_count`=255. Pixels with `display_enable`=0 or outside the ROI bounds (x=99, x=220, y=180) -> not counted, `in_roi`=0.
